// File: rtl/menu_pkg.sv
// Shared constants for the menu text renderer: geometry defaults, RAM map and fetch FSM encoding.
// The optional MENU_INVERSE_EN macro is consumed by menu_cell_fetch.
package menu_pkg;

  localparam int ADDR_W   = 11;
  localparam int COLS_DEF = 32;
  localparam int ROWS_DEF = 28;

  localparam logic [ADDR_W-1:0] TEXT_BASE_DEF = 11'h000;
  localparam logic [ADDR_W-1:0] FONT_BASE_DEF = 11'h400;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE    = 2'd0;
  localparam fetch_state_t ST_RD_CHAR = 2'd1;
  localparam fetch_state_t ST_RD_FONT = 2'd2;
  localparam fetch_state_t ST_LOAD    = 2'd3;

  // Glyph g, row r lives at base + {g[6:0], r[2:0]}.
  function automatic logic [ADDR_W-1:0] font_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [6:0]        glyph,
                                                  input logic [2:0]        row);
    return base + {1'b0, glyph, row};
  endfunction

endpackage

// File: rtl/menu_cell_fetch.sv
// Cell fetch engine: reads a character code, then its glyph row, and parks the byte in next_reg.
// MENU_INVERSE_EN: char bit 7 selects an inverted glyph byte (highlight bar).
module menu_cell_fetch
  import menu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FONT_BASE = FONT_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_cell_addr,
  input  logic [2:0]        i_glyph_row,
  input  logic [7:0]        i_ram_dout,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_ce,
  output logic [7:0]        o_next_byte,
  output logic              o_next_valid
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_cell_addr;
  logic [2:0]        r_row;
  logic [7:0]        r_next;
  logic              r_next_valid;
  logic [7:0]        w_font_load;

`ifdef MENU_INVERSE_EN
  logic r_inv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inv <= 1'b0;
    end else if (!i_start && r_state == ST_RD_FONT) begin
      r_inv <= i_ram_dout[7];
    end
  end

  assign w_font_load = r_inv ? ~i_ram_dout : i_ram_dout;
`else
  assign w_font_load = i_ram_dout;
`endif

  // A new start always wins: an in-flight fetch is abandoned and its data never reaches next_reg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cell_addr  <= '0;
      r_row        <= '0;
      r_next       <= '0;
      r_next_valid <= 1'b0;
    end else if (i_start) begin
      r_state      <= ST_RD_CHAR;
      r_cell_addr  <= i_cell_addr;
      r_row        <= i_glyph_row;
      r_next_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_RD_CHAR: r_state <= ST_RD_FONT;
        ST_RD_FONT: r_state <= ST_LOAD;
        ST_LOAD: begin
          r_next       <= w_font_load;
          r_next_valid <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Glyph address comes straight off the RAM data so the whole fetch fits in three clocks.
  always_comb begin
    o_ram_addr = '0;
    o_ram_ce   = 1'b0;
    case (r_state)
      ST_RD_CHAR: begin
        o_ram_addr = r_cell_addr;
        o_ram_ce   = 1'b1;
      end
      ST_RD_FONT: begin
        o_ram_addr = font_addr(FONT_BASE, i_ram_dout[6:0], r_row);
        o_ram_ce   = 1'b1;
      end
      default: begin
        o_ram_addr = '0;
        o_ram_ce   = 1'b0;
      end
    endcase
  end

  assign o_next_byte  = r_next;
  assign o_next_valid = r_next_valid;

endmodule

// File: rtl/menu_text_renderer.sv
// Menu OSD text renderer: pixel/line counters, glyph shift register and fetch triggering.
// Build option MENU_INVERSE_EN (inverse-video cells) is handled inside menu_cell_fetch.
module menu_text_renderer
  import menu_pkg::*;
#(
  parameter int                COLS      = COLS_DEF,
  parameter int                ROWS      = ROWS_DEF,
  parameter logic [ADDR_W-1:0] TEXT_BASE = TEXT_BASE_DEF,
  parameter logic [ADDR_W-1:0] FONT_BASE = FONT_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic              vs,
  input  logic              de,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce,
  input  logic [7:0]        ram_dout,
  output logic              out_de,
  output logic              pixel
);

  localparam int LINE_PX   = COLS * 8;
  localparam int PX_W      = $clog2(LINE_PX);
  localparam int COL_W     = $clog2(COLS);
  localparam int LAST_LINE = ROWS * 8;
  localparam int LINE_W    = $clog2(LAST_LINE + 1);

  logic [PX_W-1:0]   r_px;
  logic [LINE_W-1:0] r_line;
  logic              r_de_d;
  logic              r_armed;
  logic [7:0]        r_shift;
  logic              r_pixel;
  logic              r_out_de;

  logic [COL_W-1:0]  w_col;
  logic [LINE_W-1:0] w_line_next;
  logic              w_in_frame;
  logic              w_visible;
  logic              w_cell_start;
  logic              w_active;
  logic              w_de_fall;
  logic              w_start;
  logic [LINE_W-1:0] w_fetch_line;
  logic [COL_W-1:0]  w_fetch_col;
  logic [ADDR_W-1:0] w_cell_addr;
  logic [7:0]        w_next_byte;
  logic              w_next_valid;

  // Line counter parks one past the last text line until the next vs.
  function automatic logic [LINE_W-1:0] line_sat_inc(input logic [LINE_W-1:0] l);
    return (l < LINE_W'(LAST_LINE)) ? l + LINE_W'(1) : l;
  endfunction

  assign w_col        = r_px[PX_W-1:3];
  assign w_line_next  = line_sat_inc(r_line);
  assign w_in_frame   = r_line < LINE_W'(LAST_LINE);
  assign w_visible    = r_armed & w_in_frame;
  assign w_cell_start = r_px[2:0] == 3'd0;
  assign w_active     = pix_ce & de & ~vs;
  assign w_de_fall    = pix_ce & ~de & ~vs & r_de_d;

  // Fetch target: vs and line end prefetch column 0; a cell boundary prefetches the next column.
  always_comb begin
    w_start      = 1'b0;
    w_fetch_line = r_line;
    w_fetch_col  = '0;
    if (pix_ce && vs) begin
      w_start      = 1'b1;
      w_fetch_line = '0;
    end else if (w_de_fall && r_armed && (w_line_next < LINE_W'(LAST_LINE))) begin
      w_start      = 1'b1;
      w_fetch_line = w_line_next;
    end else if (w_active && r_armed && w_in_frame && w_cell_start &&
                 (w_col != COL_W'(COLS - 1))) begin
      w_start     = 1'b1;
      w_fetch_col = w_col + COL_W'(1);
    end
  end

  assign w_cell_addr = TEXT_BASE + ADDR_W'({w_fetch_line[LINE_W-1:3], w_fetch_col});

  menu_cell_fetch #(
    .FONT_BASE (FONT_BASE)
  ) u_fetch (
    .clk          (clk),
    .reset        (reset),
    .i_start      (w_start),
    .i_cell_addr  (w_cell_addr),
    .i_glyph_row  (w_fetch_line[2:0]),
    .i_ram_dout   (ram_dout),
    .o_ram_addr   (ram_addr),
    .o_ram_ce     (ram_ce),
    .o_next_byte  (w_next_byte),
    .o_next_valid (w_next_valid)
  );

  // Pixel stage: one registered pixel per pix_ce, bit 0 of the glyph byte is the leftmost pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_px     <= '0;
      r_line   <= '0;
      r_de_d   <= 1'b0;
      r_armed  <= 1'b0;
      r_shift  <= '0;
      r_pixel  <= 1'b0;
      r_out_de <= 1'b0;
    end else if (pix_ce) begin
      r_de_d <= de;
      if (vs) begin
        r_line   <= '0;
        r_px     <= '0;
        r_armed  <= 1'b1;
        r_shift  <= '0;
        r_pixel  <= 1'b0;
        r_out_de <= 1'b0;
      end else if (de) begin
        r_px     <= r_px + PX_W'(1);
        r_out_de <= r_armed;
        if (w_cell_start) begin
          r_shift <= w_next_valid ? {1'b0, w_next_byte[7:1]} : 8'h00;
          r_pixel <= w_visible & w_next_valid & w_next_byte[0];
        end else begin
          r_shift <= {1'b0, r_shift[7:1]};
          r_pixel <= w_visible & r_shift[0];
        end
      end else begin
        r_out_de <= 1'b0;
        r_pixel  <= 1'b0;
        if (r_de_d) begin
          r_px   <= '0;
          r_line <= w_line_next;
        end
      end
    end
  end

  assign out_de = r_out_de;
  assign pixel  = r_pixel;

endmodule

// File: tb/tb_menu_text_renderer.sv
// Scoreboard bench for menu_text_renderer: directed frames against a small RAM model.
module tb_menu_text_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_ce;
  logic        vs;
  logic        de;
  logic [10:0] ram_addr;
  logic        ram_ce;
  logic [7:0]  ram_dout = 8'h00;
  logic        out_de;
  logic        pixel;

  logic [7:0]  mem [0:2047];

  typedef struct {
    logic de;
    logic pix;
    int   line;
    int   px;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [10:0] rd_q [$];
  logic [10:0] ea;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   div   = 1;
  int   tb_line = 0;
  int   tb_px   = 0;
  logic tb_armed = 1'b0;
  logic tb_de_d  = 1'b0;

  int hand_a [16] = '{0,0,1,1,0,0,0,0, 0,0,0,1,1,0,0,0};
  int hand_b [8]  = '{1,0,1,0,0,1,0,1};
`ifdef MENU_INVERSE_EN
  int hand_c [8]  = '{1,1,0,0,1,1,1,1};
`else
  int hand_c [8]  = '{0,0,1,1,0,0,0,0};
`endif

  always #5 clk = ~clk;

  menu_text_renderer dut (
    .clk      (clk),
    .reset    (reset),
    .pix_ce   (pix_ce),
    .vs       (vs),
    .de       (de),
    .ram_addr (ram_addr),
    .ram_ce   (ram_ce),
    .ram_dout (ram_dout),
    .out_de   (out_de),
    .pixel    (pixel)
  );

  always @(posedge clk) if (ram_ce) ram_dout <= mem[ram_addr];

  always @(negedge clk) if (ram_ce) rd_q.push_back(ram_addr);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic ref_pix(input int ln, input int p);
    logic [7:0] ch;
    logic [7:0] f;
    if (ln >= 224) return 1'b0;
    ch = mem[(ln / 8) * 32 + p / 8];
    f  = mem[1024 + int'(ch[6:0]) * 8 + ln % 8];
`ifdef MENU_INVERSE_EN
    if (ch[7]) f = ~f;
`endif
    return f[p % 8];
  endfunction

  // One pixel period: drive inputs, queue the expected response, track the reference counters.
  task automatic pix(input logic d, input logic v, input int ovr);
    exp_t e;
    @(negedge clk);
    pix_ce = 1'b1;
    de     = d;
    vs     = v;
    if (v) begin
      tb_armed = 1'b1;
      tb_line  = 0;
      tb_px    = 0;
    end
    e.de   = d & tb_armed & ~v;
    e.pix  = e.de ? ((ovr >= 0) ? ovr[0] : ref_pix(tb_line, tb_px)) : 1'b0;
    e.line = tb_line;
    e.px   = tb_px;
    exp_q.push_back(e);
    if (v) begin
      tb_de_d = 1'b0;
    end else if (d) begin
      tb_px++;
      tb_de_d = 1'b1;
    end else begin
      if (tb_de_d) begin
        tb_px = 0;
        if (tb_line < 224) tb_line++;
      end
      tb_de_d = 1'b0;
    end
    for (int k = 1; k < div; k++) begin
      @(negedge clk);
      pix_ce = 1'b0;
    end
  endtask

  task automatic blank(input int n);
    for (int k = 0; k < n; k++) pix(1'b0, 1'b0, -1);
  endtask

  task automatic full_line();
    for (int k = 0; k < 256; k++) pix(1'b1, 1'b0, -1);
  endtask

  always @(posedge clk) begin
    if (pix_ce && !reset) begin
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: out_de=%0b pixel=%0b with no expected entry", out_de, pixel);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("out_de L%0d P%0d", mon_e.line, mon_e.px), 32'(out_de), 32'(mon_e.de));
        check($sformatf("pixel L%0d P%0d", mon_e.line, mon_e.px), 32'(pixel), 32'(mon_e.pix));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h000] = 8'h41;
    mem[11'h608] = 8'h0C;
    mem[11'h001] = 8'h21;
    mem[11'h508] = 8'h18;
    mem[11'h020] = 8'h02;
    mem[11'h410] = 8'hA5;

    reset = 1'b1; pix_ce = 1'b0; vs = 1'b0; de = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_ce",   32'(ram_ce),   32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_pixel",    32'(pixel),    32'h0);
    check("rst_out_de",   32'(out_de),   32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Frame A, pixel every clock: first two cells, then reset in the middle of line 1.
    div = 1;
    pix(1'b0, 1'b1, -1);
    blank(5);
    for (int i = 0; i < 256; i++) pix(1'b1, 1'b0, (i < 16) ? hand_a[i] : -1);
    blank(5);
    for (int i = 0; i < 100; i++) pix(1'b1, 1'b0, -1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    pix_ce = 1'b0;
    exp_q.delete();
    tb_armed = 1'b0; tb_line = 0; tb_px = 0; tb_de_d = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_pixel",  32'(pixel),  32'h0);
    check("midrst_out_de", 32'(out_de), 32'h0);
    check("midrst_ram_ce", 32'(ram_ce), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd_q.delete();
    for (int i = 0; i < 20; i++) pix(1'b1, 1'b0, -1);
    blank(5);
    check("unarmed_reads", 32'(rd_q.size()), 32'd0);

    // Frame B, pixel every third clock: full read sequence of line 0 and first reads of line 8.
    div = 3;
    rd_q.delete();
    pix(1'b0, 1'b1, -1);
    blank(5);
    full_line();
    blank(5);
    check("rd_count_line0", 32'(rd_q.size()), 32'd66);
    for (int k = 0; k < 66; k++) begin
      if      (k == 1)     ea = 11'h608;
      else if (k == 3)     ea = 11'h508;
      else if (k == 64)    ea = 11'h000;
      else if (k == 65)    ea = 11'h609;
      else if (k % 2 == 0) ea = 11'(k / 2);
      else                 ea = 11'h400;
      if (k < rd_q.size()) check($sformatf("rd_seq[%0d]", k), 32'(rd_q[k]), 32'(ea));
    end
    for (int ln = 1; ln < 8; ln++) begin
      full_line();
      if (ln == 7) rd_q.delete();
      blank(5);
    end
    for (int i = 0; i < 256; i++) pix(1'b1, 1'b0, (i < 8) ? hand_b[i] : -1);
    blank(5);
    if (rd_q.size() >= 2) begin
      check("line8_rd0", 32'(rd_q[0]), 32'h020);
      check("line8_rd1", 32'(rd_q[1]), 32'h410);
    end else begin
      check("line8_rd_count", 32'(rd_q.size()), 32'd2);
    end

    // Remaining rows with minimal de, then the first line past the last text row.
    div = 1;
    for (int ln = 9; ln < 224; ln++) begin
      pix(1'b1, 1'b0, -1);
      blank(5);
    end
    rd_q.delete();
    full_line();
    blank(5);
    for (int ln = 0; ln < 2; ln++) begin
      pix(1'b1, 1'b0, -1);
      blank(5);
    end
    check("no_reads_past_last_row", 32'(rd_q.size()), 32'd0);

    // Frame C: highlighted cell at (0,0); vs restarts fetching at address 0.
    mem[11'h000] = 8'hC1;
    rd_q.delete();
    pix(1'b0, 1'b1, -1);
    blank(5);
    check("vs_rd_count", 32'(rd_q.size()), 32'd2);
    if (rd_q.size() >= 2) begin
      check("vs_rd0", 32'(rd_q[0]), 32'h000);
      check("vs_rd1", 32'(rd_q[1]), 32'h608);
    end
    for (int i = 0; i < 256; i++) pix(1'b1, 1'b0, (i < 8) ? hand_c[i] : -1);
    blank(5);

    @(negedge clk);
    pix_ce = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
